// File: rtl/decade_counter_n.sv
// rtl/decade_counter_n.sv - cascaded modulo-N up/down digit counter with load, clear, wrap pulse and sticky overflow
module decade_counter_n #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10,
  parameter int DW      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 out,
  output logic                 ovf
);

  localparam logic [DW:0]   MODW = (DW+1)'(MODULUS);
  localparam logic [DW-1:0] TOP  = DW'(MODULUS - 1);

  logic [DIGITS*DW-1:0] count_nxt;
  logic [DIGITS*DW-1:0] load_clamped;
  logic [DIGITS:0]      step;
  logic                 wrap;

  // step[i] means digit i moves this cycle; it ripples through terminal digits.
  always_comb begin
    count_nxt    = count;
    load_clamped = '0;
    step         = '0;
    step[0]      = en;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, load_val[i*DW +: DW]} >= MODW)
        load_clamped[i*DW +: DW] = TOP;
      else
        load_clamped[i*DW +: DW] = load_val[i*DW +: DW];

      if (up)
        step[i+1] = step[i] && (count[i*DW +: DW] == TOP);
      else
        step[i+1] = step[i] && (count[i*DW +: DW] == '0);

      // Out-of-range digits snap to the wrap target of the current direction.
      if (step[i]) begin
        if (up) begin
          if ({1'b0, count[i*DW +: DW]} >= MODW - 1'b1)
            count_nxt[i*DW +: DW] = '0;
          else
            count_nxt[i*DW +: DW] = count[i*DW +: DW] + 1'b1;
        end else begin
          if (count[i*DW +: DW] == '0 || {1'b0, count[i*DW +: DW]} >= MODW)
            count_nxt[i*DW +: DW] = TOP;
          else
            count_nxt[i*DW +: DW] = count[i*DW +: DW] - 1'b1;
        end
      end
    end
    wrap = step[DIGITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      out   <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      out   <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      out   <= 1'b0;
    end else begin
      count <= count_nxt;
      out   <= wrap;
      if (wrap)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decade_counter_n.sv
// tb/tb_decade_counter_n.sv - directed self-checking bench for decade_counter_n
module tb_decade_counter_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 0, up = 1, clr = 0, load = 0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        out, ovf;

  logic        en2 = 0, up2 = 1, clr2 = 0, load2 = 0;
  logic [7:0]  load_val2 = '0;
  logic [7:0]  count2;
  logic        out2, ovf2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decade_counter_n #(.DIGITS(4), .MODULUS(10), .DW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .out(out), .ovf(ovf)
  );

  decade_counter_n #(.DIGITS(2), .MODULUS(10), .DW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .clr(clr2), .load(load2),
    .load_val(load_val2), .count(count2), .out(out2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (count !== 16'h0000 || out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset4: count=%h out=%b ovf=%b, required 0000 0 0", count, out, ovf);
    end
    checks++;
    if (count2 !== 8'h00 || out2 !== 1'b0 || ovf2 !== 1'b0) begin
      failures++;
      $display("FAIL reset2: count=%h out=%b ovf=%b, required 00 0 0", count2, out2, ovf2);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_release: count=%h, required 0000", count);
    end
  endtask

  task automatic test_up_two_digit();
    logic [7:0] exp;
    en2 = 1'b1; up2 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp = {4'((k % 100) / 10), 4'(k % 10)};
      checks++;
      if (count2 !== exp || out2 !== (k == 100) || ovf2 !== (k == 100)) begin
        failures++;
        $display("FAIL up2 step %0d: count=%h out=%b ovf=%b, required %h %b %b",
                 k, count2, out2, ovf2, exp, k == 100, k == 100);
      end
    end
    en2 = 1'b0;
    tick();
    checks++;
    if (count2 !== 8'h00 || out2 !== 1'b0 || ovf2 !== 1'b1) begin
      failures++;
      $display("FAIL up2 hold: count=%h out=%b ovf=%b, required 00 0 1", count2, out2, ovf2);
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_val = 16'h0A5F;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 16'h0959 || out !== 1'b0) begin
      failures++;
      $display("FAIL load_clamp: count=%h out=%b, required 0959 0", count, out);
    end
    en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    checks++;
    if (count !== 16'h0958) begin
      failures++;
      $display("FAIL load_then_down: count=%h, required 0958", count);
    end
  endtask

  task automatic test_down_wrap();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    checks++;
    if (count !== 16'h9999 || out !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap: count=%h out=%b ovf=%b, required 9999 1 1", count, out, ovf);
    end
    tick();
    checks++;
    if (count !== 16'h9999 || out !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap_after: count=%h out=%b ovf=%b, required 9999 0 1", count, out, ovf);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count !== 16'h0000 || out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_after_wrap: count=%h out=%b ovf=%b, required 0000 0 0", count, out, ovf);
    end
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 16'h1234;
    tick();
    clr = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count !== 16'h0000) begin
      failures++;
      $display("FAIL clr_over_load: count=%h, required 0000", count);
    end
    load_val = 16'h0042;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (count !== 16'h0042 || out !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en: count=%h out=%b, required 0042 0", count, out);
    end
  endtask

  task automatic test_enable_toggle();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0010; exp_seq[1] = 16'h0010;
    exp_seq[2] = 16'h0011; exp_seq[3] = 16'h0011;
    load = 1'b1; load_val = 16'h0009;
    tick();
    load = 1'b0; up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      en = (k % 2 == 0);
      tick();
      checks++;
      if (count !== exp_seq[k]) begin
        failures++;
        $display("FAIL en_toggle %0d: count=%h, required %h", k, count, exp_seq[k]);
      end
    end
    load = 1'b1; load_val = 16'h0010; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    checks++;
    if (count !== 16'h0009 || out !== 1'b0) begin
      failures++;
      $display("FAIL dir_flip: count=%h out=%b, required 0009 0", count, out);
    end
  endtask

  task automatic test_back_to_back();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en = 1'b1; up = 1'b0;
    tick();
    checks++;
    if (count !== 16'h9999 || out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: count=%h out=%b, required 9999 1", count, out);
    end
    up = 1'b1;
    tick();
    checks++;
    if (count !== 16'h0000 || out !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: count=%h out=%b ovf=%b, required 0000 1 1", count, out, ovf);
    end
    tick();
    checks++;
    if (count !== 16'h0001 || out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_third: count=%h out=%b, required 0001 0", count, out);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; up = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000 || out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL async_reset4: count=%h out=%b ovf=%b, required 0000 0 0", count, out, ovf);
    end
    checks++;
    if (ovf2 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset2: ovf=%b, required 0", ovf2);
    end
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_two_digit();
    test_load_clamp();
    test_down_wrap();
    test_priority();
    test_enable_toggle();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
